pipe_out_fifo: RTL and testbench

- Buffer between the pseudorandom/count pattern generator and the host Pipe Out endpoint.
- Accepts 64-bit words from the generator and reports occupancy back to it, so the generator can throttle against a threshold.
- Delivers 32-bit words to the host read strobe with one-cycle read latency.
- Both sides share one clock domain. Storage is a simple dual-port RAM inferable as block RAM.

---
 rtl/pipe_out_fifo.sv | 104 ++++++++++
 tb/tb_pipe_out_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_fifo.sv
// Width-converting FIFO: 64-bit words in from the pattern generator, 32-bit words
// out to the host Pipe Out read strobe (low half first), single clock domain.
module pipe_out_fifo #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    // Strobe semantics on both sides: a strobe is accepted on a rising edge only
    // when the matching flag (full / empty) is low at that edge; a strobe seen
    // while the flag is high is dropped and sets the sticky overflow / underflow.
    input  logic              wr_en,
    input  logic [63:0]       wr_data,
    output logic [ADDR_W-1:0] wr_count,
    output logic              full,
    output logic              overflow,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic [ADDR_W+1:0] rd_count,
    output logic              empty,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       r_mem [DEPTH];
    logic [63:0]       r_rd_word;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_entries;
    logic              r_half;
    logic              r_rd_hi;
    logic              r_rd_seen;
    logic              r_overflow;
    logic              r_underflow;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_free;

    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;
    assign w_free   = w_rd_acc & r_half;

    // RAM arrays carry no reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_rd_word <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_entries   <= '0;
            r_half      <= 1'b0;
            r_rd_hi     <= 1'b0;
            r_rd_seen   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_hi   <= r_half;
                r_rd_seen <= 1'b1;
                r_half    <= ~r_half;
            end
            if (w_free) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_free})
                2'b10:   r_entries <= r_entries + 1'b1;
                2'b01:   r_entries <= r_entries - 1'b1;
                default: r_entries <= r_entries;
            endcase
            if (wr_en & full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // The half-select is registered alongside the RAM read, so rd_data only moves
    // on an accepted read; before the first read after reset it is forced to zero.
    assign rd_data   = r_rd_seen ? (r_rd_hi ? r_rd_word[63:32] : r_rd_word[31:0]) : 32'h0;
    assign full      = (r_entries == FULL_CNT);
    assign empty     = (r_entries == '0);
    assign rd_count  = {r_entries, 1'b0} - {{(ADDR_W + 1){1'b0}}, r_half};
    assign wr_count  = r_entries[ADDR_W] ? {ADDR_W{1'b1}} : r_entries[ADDR_W-1:0];
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Bench for pipe_out_fifo: a word-level queue model predicts read data and
// status; a monitor compares rd_data on the falling edge after every rd_en.
module tb_pipe_out_fifo;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [63:0]       wr_data;
    logic [ADDR_W-1:0] wr_count;
    logic              full;
    logic              overflow;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic [ADDR_W+1:0] rd_count;
    logic              empty;
    logic              underflow;

    pipe_out_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_count (wr_count),
        .full     (full),
        .overflow (overflow),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_count (rd_count),
        .empty    (empty),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mq[$];
    logic [31:0] m_rd;
    bit          m_ovf;
    bit          m_udf;
    logic        mon_pend;
    logic [31:0] mon_exp;
    logic [63:0] lfsr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_entries();
        return (mq.size() + 1) / 2;
    endfunction

    task automatic check_status(input string name);
        int          e;
        logic [23:0] ev;
        e  = m_entries();
        ev = {(e >= DEPTH) ? 9'h1FF : 9'(e), 11'(mq.size()), (e == DEPTH), (mq.size() == 0), m_ovf, m_udf};
        check(name, {40'h0, wr_count, rd_count, full, empty, overflow, underflow}, {40'h0, ev});
    endtask

    // Drive one cycle; the model is evaluated on the state before the edge.
    task automatic step(input logic we, input logic [63:0] wd, input logic re);
        bit acc_w;
        bit acc_r;
        acc_w   = we && (m_entries() < DEPTH);
        acc_r   = re && (mq.size() > 0);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        if (we && !acc_w) m_ovf = 1'b1;
        if (re && !acc_r) m_udf = 1'b1;
        if (acc_r) m_rd = mq.pop_front();
        if (re) exp_q.push_back(m_rd);
        if (acc_w) begin
            mq.push_back(wd[31:0]);
            mq.push_back(wd[63:32]);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_status("status");
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b0, 64'h0, 1'b0);
        #2;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_status("status_after_reset");
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) mon_pend <= 1'b0;
        else       mon_pend <= rd_en;
    end

    always @(negedge clk) begin
        if (mon_pend) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(mon_exp));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_status("status_in_reset");
        check("rd_data_reset", 64'(rd_data), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Two entries, four 32-bit reads: 1,1,2,2
        step(1'b1, 64'h0000_0001_0000_0001, 1'b0);
        step(1'b1, 64'h0000_0002_0000_0002, 1'b0);
        check("wr_count_2", 64'(wr_count), 64'd2);
        check("rd_count_4", 64'(rd_count), 64'd4);
        repeat (4) step(1'b0, 64'h0, 1'b1);
        repeat (2) step(1'b0, 64'h0, 1'b0);
        check("empty_after_4", 64'(empty), 64'd1);
        check("wr_count_0", 64'(wr_count), 64'd0);

        // Fill to 512, then a dropped 513th write
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, {32'(i) + 32'h100, 32'(i)}, 1'b0);
        end
        step(1'b1, 64'hDEAD, 1'b0);
        check("full_at_512", 64'(full), 64'd1);
        check("wr_count_sat", 64'(wr_count), 64'd511);
        check("overflow_set", 64'(overflow), 64'd1);
        check("rd_count_full", 64'(rd_count), 64'd1024);
        for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 64'h0, 1'b1);
        check("empty_after_drain", 64'(empty), 64'd1);

        // Underflow from empty, and a same-cycle write that is not yet readable
        do_reset();
        step(1'b0, 64'h0, 1'b1);
        check("underflow_set", 64'(underflow), 64'd1);
        check("rd_count_empty", 64'(rd_count), 64'd0);
        step(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b0);

        // Continuous write+read with LFSR data
        do_reset();
        lfsr = 64'h1234_5678_9ABC_DEF1;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, lfsr, 1'b1);
            lfsr = lfsr_next(lfsr);
        end
        check("overflow_stream", 64'(overflow), 64'd1);
        for (int i = 0; i < 2 * DEPTH + 2 && mq.size() > 0; i++) step(1'b0, 64'h0, 1'b1);

        // Asynchronous reset mid-clock with 300 entries and half=1
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, {32'hF000_0000 | 32'(i), 32'(i)}, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b0);
        check("rd_count_599", 64'(rd_count), 64'd599);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_status("status_async_reset");
        check("rd_data_async_reset", 64'(rd_data), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 64'h5, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b0);

        // Pointer wrap: 3 x 512 words with occupancy held around 5-6 entries
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, {32'hC000_0000 | 32'(i), 32'(i)}, 1'b0);
        for (int i = 5; i < 5 + 3 * DEPTH; i++) begin
            step(1'b1, {32'hC000_0000 | 32'(i), 32'(i)}, 1'b1);
            step(1'b0, 64'h0, 1'b1);
        end
        check("wrap_overflow_clear", 64'(overflow), 64'd0);
        check("wrap_underflow_clear", 64'(underflow), 64'd0);
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) step(1'b0, 64'h0, 1'b1);
        repeat (3) step(1'b0, 64'h0, 1'b0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
